// File: rtl/halt_pkg.sv
// Shared types and constants for the halt controller, decode stage and testbench.
package halt_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    localparam logic [2:0] REASON_NONE     = 3'd0;
    localparam logic [2:0] REASON_ECALL    = 3'd1;
    localparam logic [2:0] REASON_EBREAK   = 3'd2;
    localparam logic [2:0] REASON_WATCHDOG = 3'd3;
    localparam logic [2:0] REASON_EXTERNAL = 3'd4;

    localparam int HALT_CODE_DEFAULT = 10;

endpackage

// File: rtl/halt_watchdog.sv
// Saturating RUN-cycle counter with the watchdog-limit compare.
module halt_watchdog #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wd_hit
);

    localparam bit             WD_ON   = (MAX_CYCLES != 0);
    // When the watchdog is off this value is never used (WD_ON gates it).
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_en && (r_count != '1))
            r_count <= r_count + CNT_W'(1);
    end

    assign o_count  = r_count;
    assign o_wd_hit = WD_ON && (r_count == WD_LAST);

endmodule

// File: rtl/halt_controller.sv
// Detects termination events beside decode, stops fetch, drains the pipe,
// then raises a sticky halted flag with the winning reason code.
module halt_controller
    import halt_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int HALT_CODE    = HALT_CODE_DEFAULT,
    parameter int EBREAK_HALT  = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             is_ecall,
    input  logic             is_ebreak,
    input  logic [XLEN-1:0]  x17,
    input  logic             force_halt,
    output logic             halt_req,
    output logic             is_halted,
    output logic [2:0]       halt_reason,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    halt_state_t     r_state;
    logic [DW-1:0]   r_drain;
    logic            r_halt_req;
    logic            r_halted;
    logic [2:0]      r_reason;

    logic            w_run;
    logic            w_accept;
    logic            w_ecall_hit;
    logic            w_ebreak_hit;
    logic            w_wd_hit;
    logic            w_any_hit;
    logic [2:0]      w_hit_reason;

    assign w_run        = (r_state == RUN);
    assign w_accept     = inst_valid & ~stall & ~flush;
    assign w_ecall_hit  = w_accept & is_ecall & (x17 == XLEN'(HALT_CODE));
    assign w_ebreak_hit = w_accept & is_ebreak & (EBREAK_HALT != 0);
    assign w_any_hit    = w_ecall_hit | w_ebreak_hit | w_wd_hit;

    halt_watchdog #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_run),
        .o_count  (cycle_count),
        .o_wd_hit (w_wd_hit)
    );

    // force_halt outranks these and is resolved inside the FSM.
    always_comb begin
        w_hit_reason = REASON_NONE;
        if (w_ecall_hit)
            w_hit_reason = REASON_ECALL;
        else if (w_ebreak_hit)
            w_hit_reason = REASON_EBREAK;
        else if (w_wd_hit)
            w_hit_reason = REASON_WATCHDOG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_drain    <= '0;
            r_halt_req <= 1'b0;
            r_halted   <= 1'b0;
            r_reason   <= REASON_NONE;
        end else begin
            case (r_state)
                RUN: begin
                    if (force_halt) begin
                        r_state    <= HALTED;
                        r_halt_req <= 1'b1;
                        r_halted   <= 1'b1;
                        r_reason   <= REASON_EXTERNAL;
                    end else if (w_any_hit) begin
                        r_halt_req <= 1'b1;
                        r_reason   <= w_hit_reason;
                        if (DRAIN_CYCLES == 0) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                            r_drain <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    // Reason from the original trigger survives a late force_halt.
                    if (force_halt || (r_drain == '0)) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                HALTED: ;
                default: r_state <= RUN;
            endcase
        end
    end

    assign halt_req    = r_halt_req;
    assign is_halted   = r_halted;
    assign halt_reason = r_reason;

endmodule

// File: tb/tb_halt_controller.sv
// Three differently parameterised controllers share one stimulus stream and are
// checked against an event-time model of the halt rules.
module tb_halt_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        is_ecall = 1'b0, is_ebreak = 1'b0, force_halt = 1'b0;
    logic [31:0] x17 = '0;

    logic [2:0]  req, hlt;
    logic [2:0]  rsn [3];
    logic [31:0] cnt [3];
    logic [31:0] cnt0_w, cnt1_w;
    logic [2:0]  cnt2_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // d0: drain 4, ebreak halts; d1: no drain, ebreak ignored, watchdog 20;
    // d2: drain 1, 3-bit counter to exercise saturation.
    halt_controller #(.DRAIN_CYCLES(4), .EBREAK_HALT(1), .MAX_CYCLES(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .stall(stall), .flush(flush),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .x17(x17), .force_halt(force_halt),
        .halt_req(req[0]), .is_halted(hlt[0]), .halt_reason(rsn[0]), .cycle_count(cnt0_w));
    halt_controller #(.DRAIN_CYCLES(0), .EBREAK_HALT(0), .MAX_CYCLES(20), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .stall(stall), .flush(flush),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .x17(x17), .force_halt(force_halt),
        .halt_req(req[1]), .is_halted(hlt[1]), .halt_reason(rsn[1]), .cycle_count(cnt1_w));
    halt_controller #(.DRAIN_CYCLES(1), .EBREAK_HALT(1), .MAX_CYCLES(0), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .stall(stall), .flush(flush),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .x17(x17), .force_halt(force_halt),
        .halt_req(req[2]), .is_halted(hlt[2]), .halt_reason(rsn[2]), .cycle_count(cnt2_w));

    assign cnt[0] = cnt0_w;
    assign cnt[1] = cnt1_w;
    assign cnt[2] = {29'd0, cnt2_w};

    // Model: per controller, the edge at which it triggered and the edge after
    // which is_halted is due; outputs follow from those times.
    int P_D [3] = '{4, 0, 1};
    int P_E [3] = '{1, 0, 1};
    int P_M [3] = '{0, 20, 0};
    int P_W [3] = '{32, 32, 3};

    int     m_n;
    int     m_trig [3];
    int     m_halt [3];
    int     m_rsn  [3];
    longint m_cnt  [3];

    task automatic model_reset();
        m_n = 0;
        for (int k = 0; k < 3; k++) begin
            m_trig[k] = -1; m_halt[k] = -1; m_rsn[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit acc, ec, eb, wd;
        longint cmax;
        m_n++;
        acc = inst_valid && !stall && !flush;
        ec  = acc && is_ecall && (x17 == 32'd10);
        for (int k = 0; k < 3; k++) begin
            eb   = acc && is_ebreak && (P_E[k] != 0);
            wd   = (P_M[k] != 0) && (m_cnt[k] == longint'(P_M[k] - 1));
            cmax = (longint'(1) << P_W[k]) - 1;
            if (m_trig[k] < 0) begin
                if (force_halt) begin
                    m_trig[k] = m_n; m_halt[k] = m_n; m_rsn[k] = 4;
                end else if (ec || eb || wd) begin
                    m_trig[k] = m_n; m_halt[k] = m_n + P_D[k];
                    m_rsn[k]  = ec ? 1 : (eb ? 2 : 3);
                end
                if (m_cnt[k] < cmax) m_cnt[k]++;
            end else if (m_n - 1 < m_halt[k]) begin
                if (force_halt) m_halt[k] = m_n;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_req@%0d", k, m_n), {31'd0, req[k]}, (m_trig[k] >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_halted@%0d", k, m_n), {31'd0, hlt[k]},
                (m_halt[k] >= 0 && m_n >= m_halt[k]) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_reason@%0d", k, m_n), {29'd0, rsn[k]}, 32'(m_rsn[k]));
            chk($sformatf("d%0d_count@%0d", k, m_n), cnt[k], 32'(m_cnt[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit v, input bit s, input bit f, input bit ec,
                          input bit eb, input logic [31:0] x, input bit fh);
        inst_valid = v; stall = s; flush = f; is_ecall = ec; is_ebreak = eb; x17 = x; force_halt = fh;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
    endtask

    // Reset is pulsed between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        idle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("reset_req_hlt_async", {26'd0, req, hlt}, 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Drain latency and frozen counter
        do_reset();
        repeat (4) tick();
        set_in(1, 0, 0, 1, 0, 32'd10, 0);
        tick();
        idle();
        chk("p1_req_e5", {31'd0, req[0]}, 32'd1);
        chk("p1_halted_e5", {31'd0, hlt[0]}, 32'd0);
        repeat (3) tick();
        chk("p1_halted_e8", {31'd0, hlt[0]}, 32'd0);
        tick();
        chk("p1_halted_e9", {31'd0, hlt[0]}, 32'd1);
        chk("p1_reason", {29'd0, rsn[0]}, 32'd1);
        chk("p1_count", cnt[0], 32'd5);
        tick();

        // Qualification: wrong code, stall, flush; then ecall+ebreak together
        do_reset();
        set_in(1, 0, 0, 1, 0, 32'd11, 0); tick();
        set_in(1, 1, 0, 1, 0, 32'd10, 0); tick();
        set_in(1, 0, 1, 1, 0, 32'd10, 0); tick();
        chk("p2_no_req", {29'd0, req}, 32'd0);
        set_in(1, 0, 0, 1, 1, 32'd10, 0); tick();
        idle();
        chk("p2_req", {31'd0, req[0]}, 32'd1);
        chk("p2_reason_ecall_wins", {29'd0, rsn[0]}, 32'd1);
        repeat (5) tick();
        chk("p2_halted", {31'd0, hlt[0]}, 32'd1);

        // Saturation, ebreak enable, watchdog
        do_reset();
        repeat (10) tick();
        chk("p3_sat", cnt[2], 32'd7);
        chk("p3_cnt0", cnt[0], 32'd10);
        set_in(1, 0, 0, 0, 1, 32'd0, 0); tick();
        idle();
        chk("p3_ebreak_reason", {29'd0, rsn[2]}, 32'd2);
        chk("p3_ebreak_ignored", {31'd0, req[1]}, 32'd0);
        repeat (8) tick();
        chk("p3_wd_e19", {31'd0, hlt[1]}, 32'd0);
        tick();
        chk("p3_wd_e20", {31'd0, hlt[1]}, 32'd1);
        chk("p3_wd_reason", {29'd0, rsn[1]}, 32'd3);
        chk("p3_wd_count", cnt[1], 32'd20);

        // force_halt during DRAIN keeps reason; in RUN gives reason 4
        do_reset();
        set_in(1, 0, 0, 1, 0, 32'd10, 0); tick();
        idle(); tick();
        set_in(0, 0, 0, 0, 0, 32'd0, 1); tick();
        idle();
        chk("p4_force_drain_halted", {31'd0, hlt[0]}, 32'd1);
        chk("p4_force_drain_reason", {29'd0, rsn[0]}, 32'd1);
        tick();
        do_reset();
        tick();
        set_in(0, 0, 0, 0, 0, 32'd0, 1); tick();
        idle();
        chk("p4_force_run_halted", {31'd0, hlt[0]}, 32'd1);
        chk("p4_force_run_reason", {29'd0, rsn[0]}, 32'd4);
        chk("p4_force_run_count", cnt[0], 32'd2);
        set_in(0, 0, 0, 0, 0, 32'd0, 1); tick();
        idle();

        // Async reset mid-DRAIN and in HALTED
        do_reset();
        set_in(1, 0, 0, 1, 0, 32'd10, 0); tick();
        idle(); tick();
        do_reset();
        set_in(1, 0, 0, 1, 0, 32'd10, 0); tick();
        idle();
        repeat (3) tick();
        chk("p5_halted_e4", {31'd0, hlt[0]}, 32'd0);
        tick();
        chk("p5_halted_e5", {31'd0, hlt[0]}, 32'd1);
        do_reset();

        // Randomised traffic
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                set_in($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
                       $urandom_range(6, 0) == 0, $urandom_range(6, 0) == 0,
                       $urandom_range(9, 0) == 0,
                       ($urandom_range(1, 0) == 1) ? 32'd10 : 32'($urandom),
                       $urandom_range(39, 0) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/halt_controller.md
Name: halt_controller

Overview:
Parametrised successor to the single-condition halt flag. Detects program-termination events (ecall with a configurable a7 code, optional ebreak, watchdog timeout, external force), requests fetch stop, drains a configurable number of in-flight pipeline stages, then raises a sticky halted flag with a latched reason code. Sits beside the decode stage of the pipelined CPU and feeds the top-level is_halted output and the testbench.

Parameters:
XLEN, 32, width of the a7 (x17) register value
HALT_CODE, 10, a7 value that makes ecall a halt request
EBREAK_HALT, 1, 1 = ebreak also halts; 0 = ebreak ignored
DRAIN_CYCLES, 4, cycles from trigger to is_halted; 0 = halt on the trigger edge itself
MAX_CYCLES, 0, watchdog limit in RUN cycles; 0 = watchdog disabled
CNT_W, 32, width of the cycle counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
inst_valid  input  1  decode-stage instruction is valid (not a bubble)
stall  input  1  decode stage stalled this cycle
flush  input  1  decode-stage instruction squashed this cycle
is_ecall  input  1  decode-stage instruction is ecall
is_ebreak  input  1  decode-stage instruction is ebreak
x17  input  XLEN  forwarded a7 value for the decode-stage instruction
force_halt  input  1  external halt, bypasses drain
halt_req  output  1  stop fetch / block new issue
is_halted  output  1  sticky halted flag
halt_reason  output  3  0 none, 1 ecall, 2 ebreak, 3 watchdog, 4 external
cycle_count  output  CNT_W  cycles spent in RUN

Behaviour:
- One clock domain; reset is asynchronous and active-high. Reset forces state RUN, halt_req=0, is_halted=0, halt_reason=0, cycle_count=0, drain counter=0, regardless of clk. Reset mid-DRAIN or in HALTED returns to RUN.
- States: RUN, DRAIN, HALTED.
- Qualified event (RUN only): `accept = inst_valid & ~stall & ~flush`.
  - ecall_hit = accept & is_ecall & (x17 == HALT_CODE). Full XLEN compare; x17 ignored otherwise.
  - ebreak_hit = accept & is_ebreak & EBREAK_HALT.
  - wd_hit = (MAX_CYCLES != 0) & (cycle_count == MAX_CYCLES-1).
- Priority for simultaneous events: force_halt > ecall > ebreak > watchdog. Only the winning reason is latched.
- RUN:
  - cycle_count increments by 1 per cycle and saturates at all-ones.
  - On any hit with DRAIN_CYCLES>0: go to DRAIN, set halt_req=1, load drain counter = DRAIN_CYCLES-1, latch halt_reason.
  - On any hit with DRAIN_CYCLES==0: go directly to HALTED.
- DRAIN:
  - halt_req stays 1 and cycle_count holds.
  - Drain counter decrements each cycle. On the edge where it reads 0, go to HALTED.
  - stall, flush and new ecall/ebreak are ignored in DRAIN; the reason is not overwritten.
- HALTED:
  - halt_req=1, is_halted=1, halt_reason held. Sticky until reset.
- force_halt:
  - From RUN or DRAIN, go to HALTED on the next edge with halt_req=1 and is_halted=1.
  - Reason=4, except when the controller is already in DRAIN: that reason is kept.
  - force_halt is ignored in HALTED.
- Latency: trigger sampled at edge N gives halt_req=1 after edge N and is_halted=1 after edge N+DRAIN_CYCLES. With DRAIN_CYCLES=0 both rise after edge N.
- All outputs are registered; no combinational path from inputs to outputs.
- Watchdog counter width: MAX_CYCLES must fit in CNT_W; the compare is done at CNT_W bits.

Decomposition:
- Shared package halt_pkg:
  - halt_state_t enum {RUN, DRAIN, HALTED}.
  - Reason constants REASON_NONE/ECALL/EBREAK/WATCHDOG/EXTERNAL (3 bits).
  - Default HALT_CODE constant (10) for reuse by decode and testbench.
- One natural sub-module: halt_watchdog, which holds the saturating cycle counter plus the wd_hit compare, with an enable tied to state==RUN.
- FSM and drain counter stay in halt_controller.

Test Plan:
- DRAIN_CYCLES=4, ecall with x17=10, inst_valid=1 at edge 5 -> halt_req=1 after edge 5, is_halted=1 after edge 9, halt_reason=1, cycle_count frozen at 5.
- ecall with x17=11, then ecall with x17=10 but stall=1, then ecall with x17=10 and flush=1 -> no halt, halt_req=0 throughout; next unstalled ecall with x17=10 halts.
- EBREAK_HALT=1 with ecall(x17=10) and ebreak asserted on the same cycle -> reason=1. EBREAK_HALT=0 with ebreak alone -> no halt.
- MAX_CYCLES=20, DRAIN_CYCLES=0, no ecall -> is_halted=1 after edge 20, reason=3, cycle_count=20.
- ecall trigger, force_halt 2 cycles into DRAIN -> is_halted next edge, reason stays 1. force_halt in RUN -> reason=4.
- Assert reset asynchronously mid-DRAIN and in HALTED, between clock edges -> all outputs 0 immediately. After release, a new ecall(x17=10) halts normally.
